// File: rtl/sdram_burst_arbiter.sv
// sdram_burst_arbiter: round-robin write/read burst request generator for the SDRAM core,
// with wrapping burst pointers inside a configurable region and FIFO strobe routing.
module sdram_burst_arbiter #(
  parameter int APP_ADDR_WIDTH  = 24,
  parameter int APP_BURST_WIDTH = 9,
  parameter int SDR_DQ_WIDTH    = 16,
  parameter int FIFO_LVL_WIDTH  = 11,
  parameter int BURST_LEN       = 256,
  parameter int ADDR_BASE       = 0,
  parameter int ADDR_SPAN       = 786432
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic                       wr_addr_clr,
  input  logic                       rd_addr_clr,
  input  logic [FIFO_LVL_WIDTH-1:0]  wr_fifo_level,
  input  logic [SDR_DQ_WIDTH-1:0]    wr_fifo_rdata,
  output logic                       wr_fifo_rd_en,
  input  logic [FIFO_LVL_WIDTH-1:0]  rd_fifo_free,
  output logic [SDR_DQ_WIDTH-1:0]    rd_fifo_wdata,
  output logic                       rd_fifo_wr_en,
  output logic                       wr_burst_req,
  output logic [APP_BURST_WIDTH-1:0] wr_burst_len,
  output logic [APP_ADDR_WIDTH-1:0]  wr_burst_addr,
  output logic [SDR_DQ_WIDTH-1:0]    wr_burst_data,
  input  logic                       wr_burst_data_req,
  input  logic                       wr_burst_finish,
  output logic                       rd_burst_req,
  output logic [APP_BURST_WIDTH-1:0] rd_burst_len,
  output logic [APP_ADDR_WIDTH-1:0]  rd_burst_addr,
  input  logic [SDR_DQ_WIDTH-1:0]    rd_burst_data,
  input  logic                       rd_burst_data_valid,
  input  logic                       rd_burst_finish,
  output logic                       busy
);
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT} state_t;
  localparam int AW = APP_ADDR_WIDTH;
  localparam logic [AW:0] BASE = (AW+1)'(ADDR_BASE);
  localparam logic [AW:0] LIMIT = (AW+1)'(ADDR_BASE + ADDR_SPAN);
  localparam logic [AW:0] STEP = (AW+1)'(BURST_LEN);
  localparam logic [FIFO_LVL_WIDTH-1:0] LVL = FIFO_LVL_WIDTH'(BURST_LEN);
  state_t state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_adv, rd_adv;
  logic [AW:0] wr_nxt, rd_nxt;
  logic wr_pend_q, wr_pend_d, rd_pend_q, rd_pend_d;
  logic lg_rd_q, lg_rd_d;
  logic wr_ok, rd_ok, wr_own, rd_own, wr_fin, rd_fin;
  assign wr_fifo_rd_en = wr_burst_data_req;
  assign wr_burst_data = wr_fifo_rdata;
  assign rd_fifo_wr_en = rd_burst_data_valid;
  assign rd_fifo_wdata = rd_burst_data;
  assign wr_burst_len  = APP_BURST_WIDTH'(BURST_LEN);
  assign rd_burst_len  = APP_BURST_WIDTH'(BURST_LEN);
  assign wr_burst_req  = state_q == WR_REQ;
  assign rd_burst_req  = state_q == RD_REQ;
  assign wr_burst_addr = wr_ptr_q;
  assign rd_burst_addr = rd_ptr_q;
  assign busy          = state_q != IDLE;
  assign wr_ok  = enable && wr_fifo_level >= LVL;
  assign rd_ok  = enable && rd_fifo_free >= LVL;
  assign wr_own = state_q == WR_REQ || state_q == WR_WAIT;
  assign rd_own = state_q == RD_REQ || state_q == RD_WAIT;
  assign wr_fin = state_q == WR_WAIT && wr_burst_finish;
  assign rd_fin = state_q == RD_WAIT && rd_burst_finish;
  // One extra bit keeps the wrap compare exact at the top of the address space
  assign wr_nxt = {1'b0, wr_ptr_q} + STEP;
  assign rd_nxt = {1'b0, rd_ptr_q} + STEP;
  assign wr_adv = wr_nxt >= LIMIT ? BASE[AW-1:0] : wr_nxt[AW-1:0];
  assign rd_adv = rd_nxt >= LIMIT ? BASE[AW-1:0] : rd_nxt[AW-1:0];
  always_comb begin
    state_d   = state_q;
    lg_rd_d   = lg_rd_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    wr_pend_d = wr_pend_q;
    rd_pend_d = rd_pend_q;
    if (wr_fin) begin
      wr_ptr_d  = (wr_addr_clr || wr_pend_q) ? BASE[AW-1:0] : wr_adv;
      wr_pend_d = 1'b0;
    end else if (wr_addr_clr) begin
      if (wr_own) wr_pend_d = 1'b1;
      else wr_ptr_d = BASE[AW-1:0];
    end
    if (rd_fin) begin
      rd_ptr_d  = (rd_addr_clr || rd_pend_q) ? BASE[AW-1:0] : rd_adv;
      rd_pend_d = 1'b0;
    end else if (rd_addr_clr) begin
      if (rd_own) rd_pend_d = 1'b1;
      else rd_ptr_d = BASE[AW-1:0];
    end
    case (state_q)
      IDLE:
        if (wr_ok && (!rd_ok || lg_rd_q)) begin
          state_d = WR_REQ;
          lg_rd_d = 1'b0;
        end else if (rd_ok) begin
          state_d = RD_REQ;
          lg_rd_d = 1'b1;
        end
      WR_REQ:  state_d = wr_burst_data_req ? WR_WAIT : WR_REQ;
      WR_WAIT: state_d = wr_burst_finish ? IDLE : WR_WAIT;
      RD_REQ:  state_d = rd_burst_data_valid ? RD_WAIT : RD_REQ;
      RD_WAIT: state_d = rd_burst_finish ? IDLE : RD_WAIT;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      lg_rd_q   <= 1'b1;
      wr_ptr_q  <= BASE[AW-1:0];
      rd_ptr_q  <= BASE[AW-1:0];
      wr_pend_q <= 1'b0;
      rd_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      lg_rd_q   <= lg_rd_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_pend_q <= wr_pend_d;
      rd_pend_q <= rd_pend_d;
    end
  end
endmodule

// File: tb/tb_sdram_burst_arbiter.sv
// tb_sdram_burst_arbiter: directed bench with a hand-driven core model; region of 1024 words
// so that pointer wrap is reached quickly.
module tb_sdram_burst_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable, wr_addr_clr, rd_addr_clr;
  logic [10:0] wr_fifo_level, rd_fifo_free;
  logic [15:0] wr_fifo_rdata, rd_fifo_wdata, wr_burst_data, rd_burst_data;
  logic        wr_fifo_rd_en, rd_fifo_wr_en;
  logic        wr_burst_req, rd_burst_req;
  logic [8:0]  wr_burst_len, rd_burst_len;
  logic [23:0] wr_burst_addr, rd_burst_addr;
  logic        wr_burst_data_req, wr_burst_finish, rd_burst_data_valid, rd_burst_finish;
  logic        busy;
  int checks = 0;
  int failures = 0;

  sdram_burst_arbiter #(.ADDR_SPAN(1024)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .wr_addr_clr(wr_addr_clr), .rd_addr_clr(rd_addr_clr),
    .wr_fifo_level(wr_fifo_level), .wr_fifo_rdata(wr_fifo_rdata), .wr_fifo_rd_en(wr_fifo_rd_en),
    .rd_fifo_free(rd_fifo_free), .rd_fifo_wdata(rd_fifo_wdata), .rd_fifo_wr_en(rd_fifo_wr_en),
    .wr_burst_req(wr_burst_req), .wr_burst_len(wr_burst_len), .wr_burst_addr(wr_burst_addr),
    .wr_burst_data(wr_burst_data), .wr_burst_data_req(wr_burst_data_req),
    .wr_burst_finish(wr_burst_finish),
    .rd_burst_req(rd_burst_req), .rd_burst_len(rd_burst_len), .rd_burst_addr(rd_burst_addr),
    .rd_burst_data(rd_burst_data), .rd_burst_data_valid(rd_burst_data_valid),
    .rd_burst_finish(rd_burst_finish), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Core model for one write burst; clr_mode 1 clears mid-burst, 2 clears with the finish
  task automatic wr_burst(input logic [23:0] exp_addr, input int clr_mode);
    int n = 0;
    int w = 0;
    while (!wr_burst_req && w < 20) begin tick(); w++; end
    chk("wr_req_up", {31'b0, wr_burst_req}, 1);
    chk("wr_addr", {8'b0, wr_burst_addr}, {8'b0, exp_addr});
    wr_fifo_rdata = 16'hA5A5 ^ exp_addr[15:0];
    #1 chk("wr_data_pass", {16'b0, wr_burst_data}, {16'b0, 16'hA5A5 ^ exp_addr[15:0]});
    wr_burst_data_req = 1'b1;
    for (int i = 0; i < 256; i++) begin
      wr_addr_clr = (clr_mode == 1 && i == 100);
      #1 n += int'(wr_fifo_rd_en);
      tick();
      if (i == 0) chk("wr_req_drop", {31'b0, wr_burst_req}, 0);
      if (i == 200) chk("wr_addr_hold", {8'b0, wr_burst_addr}, {8'b0, exp_addr});
    end
    wr_addr_clr = 1'b0;
    wr_burst_data_req = 1'b0;
    chk("wr_pops", n, 256);
    wr_burst_finish = 1'b1;
    wr_addr_clr = (clr_mode == 2);
    tick();
    wr_burst_finish = 1'b0;
    wr_addr_clr = 1'b0;
    chk("wr_idle_gap", {30'b0, busy, wr_burst_req}, 0);
  endtask

  task automatic rd_burst(input logic [23:0] exp_addr, input logic drop_en);
    int n = 0;
    int w = 0;
    while (!rd_burst_req && w < 20) begin tick(); w++; end
    chk("rd_req_up", {31'b0, rd_burst_req}, 1);
    chk("rd_addr", {8'b0, rd_burst_addr}, {8'b0, exp_addr});
    rd_burst_data = 16'h3C00 + exp_addr[15:0];
    #1 chk("rd_data_pass", {16'b0, rd_fifo_wdata}, {16'b0, 16'h3C00 + exp_addr[15:0]});
    rd_burst_data_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      if (drop_en && i == 10) enable = 1'b0;
      #1 n += int'(rd_fifo_wr_en);
      tick();
      if (i == 0) chk("rd_req_drop", {31'b0, rd_burst_req}, 0);
    end
    rd_burst_data_valid = 1'b0;
    chk("rd_pushes", n, 256);
    rd_burst_finish = 1'b1;
    tick();
    rd_burst_finish = 1'b0;
    chk("rd_idle_gap", {30'b0, busy, rd_burst_req}, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    enable = 1'b0; wr_addr_clr = 1'b0; rd_addr_clr = 1'b0;
    wr_fifo_level = '0; rd_fifo_free = '0; wr_fifo_rdata = '0; rd_burst_data = '0;
    wr_burst_data_req = 1'b0; wr_burst_finish = 1'b0;
    rd_burst_data_valid = 1'b0; rd_burst_finish = 1'b0;
    #1;
    chk("rst_reqs", {30'b0, wr_burst_req, rd_burst_req}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("wr_len", {23'b0, wr_burst_len}, 256);
    chk("rd_len", {23'b0, rd_burst_len}, 256);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    // Both eligible from reset: write first, then alternate
    enable = 1'b1; wr_fifo_level = 11'd300; rd_fifo_free = 11'd300;
    chk("idle_no_req", {30'b0, wr_burst_req, rd_burst_req}, 0);
    tick();
    chk("grant_latency", {30'b0, wr_burst_req, rd_burst_req}, 2'b10);
    wr_burst(24'd0, 0);
    rd_burst(24'd0, 1'b0);
    wr_burst(24'd256, 0);
    rd_burst(24'd256, 1'b0);
    // Writes only: mid-burst clear, then walk the region and wrap
    rd_fifo_free = 11'd0;
    wr_burst(24'd512, 1);
    wr_burst(24'd0, 0);
    wr_burst(24'd256, 0);
    wr_burst(24'd512, 0);
    wr_burst(24'd768, 0);
    wr_burst(24'd0, 0);
    // Read granted after the write; enable drops mid-burst
    rd_fifo_free = 11'd300;
    rd_burst(24'd512, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("disabled_idle", {30'b0, busy, wr_burst_req | rd_burst_req}, 0);
    end
    // Async reset during a write wait
    enable = 1'b1;
    tick(); tick();
    chk("wr_after_rd", {8'b0, wr_burst_addr}, 256);
    wr_burst_data_req = 1'b1;
    tick();
    wr_burst_data_req = 1'b0;
    tick(); tick();
    chk("in_wait", {31'b0, busy}, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_req", {31'b0, wr_burst_req}, 0);
    chk("async_rst_busy", {31'b0, busy}, 0);
    chk("async_rst_wptr", {8'b0, wr_burst_addr}, 0);
    chk("async_rst_rptr", {8'b0, rd_burst_addr}, 0);
    tick();
    rst_n = 1'b1;
    rd_fifo_free = 11'd0;
    wr_burst(24'd0, 2);
    wr_burst(24'd0, 0);
    wr_fifo_level = 11'd255; rd_fifo_free = 11'd300;
    rd_burst(24'd0, 1'b0);
    rd_fifo_free = 11'd255;
    tick(); tick();
    chk("below_len_idle", {30'b0, busy, wr_burst_req | rd_burst_req}, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sdram_burst_arbiter.md
Name: sdram_burst_arbiter

Overview:
- Upstream request generator for the SDRAM controller core; owns both burst-request interfaces of that core.
- Watches a write FIFO (camera/producer side) and a read FIFO (display/consumer side), and decides which fixed-length burst to issue next, round-robin.
- Generates linear, wrapping burst addresses inside a configurable region; routes the core's data strobes to the FIFOs.

Parameters:
- APP_ADDR_WIDTH, 24, controller word-address width (bank+row+col).
- APP_BURST_WIDTH, 9, burst-length field width.
- SDR_DQ_WIDTH, 16, data word width.
- FIFO_LVL_WIDTH, 11, width of FIFO level/free-space inputs.
- BURST_LEN, 256, words per burst; range 4..2^APP_BURST_WIDTH-1.
- ADDR_BASE, 0, first word address of the region.
- ADDR_SPAN, 24'd786432, region size in words; must be a multiple of BURST_LEN.

Ports:
- clk  in  1  system clock, same domain as controller core.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  high: new bursts may start; low: finish current burst then stay idle.
- wr_addr_clr  in  1  pulse: write pointer returns to ADDR_BASE (frame start).
- rd_addr_clr  in  1  pulse: read pointer returns to ADDR_BASE.
- wr_fifo_level  in  FIFO_LVL_WIDTH  words available in write FIFO.
- wr_fifo_rdata  in  SDR_DQ_WIDTH  write FIFO output data.
- wr_fifo_rd_en  out  1  write FIFO pop.
- rd_fifo_free  in  FIFO_LVL_WIDTH  free entries in read FIFO.
- rd_fifo_wdata  out  SDR_DQ_WIDTH  data into read FIFO.
- rd_fifo_wr_en  out  1  read FIFO push.
- wr_burst_req / wr_burst_len / wr_burst_addr  out  1/APP_BURST_WIDTH/APP_ADDR_WIDTH  to core.
- wr_burst_data  out  SDR_DQ_WIDTH  to core.
- wr_burst_data_req, wr_burst_finish  in  1 each  from core.
- rd_burst_req / rd_burst_len / rd_burst_addr  out  1/APP_BURST_WIDTH/APP_ADDR_WIDTH  to core.
- rd_burst_data  in  SDR_DQ_WIDTH  from core.
- rd_burst_data_valid, rd_burst_finish  in  1 each  from core.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_n low, async): state IDLE; wr_burst_req=rd_burst_req=0; both pointers = ADDR_BASE; last_grant=READ; busy=0. wr_burst_len and rd_burst_len are constant BURST_LEN at all times.
- Passthroughs (combinational):
  - wr_fifo_rd_en = wr_burst_data_req; wr_burst_data = wr_fifo_rdata.
  - rd_fifo_wr_en = rd_burst_data_valid; rd_fifo_wdata = rd_burst_data.
- Eligibility, evaluated in IDLE:
  - wr_ok = enable & (wr_fifo_level >= BURST_LEN).
  - rd_ok = enable & (rd_fifo_free >= BURST_LEN).
- States:
  - IDLE:
    - Both ok: grant the side opposite last_grant.
    - One ok: grant that side.
    - Next state WR_REQ or RD_REQ; last_grant updated at the grant.
  - WR_REQ: wr_burst_req=1 (registered, asserted the cycle after the grant); wr_burst_addr = wr_ptr, held stable until finish. First cycle wr_burst_data_req=1 -> req deasserted next cycle, go WR_WAIT.
  - WR_WAIT: on wr_burst_finish -> wr_ptr advance, go IDLE.
  - RD_REQ / RD_WAIT: same structure, using rd_burst_data_valid to drop the request and rd_burst_finish to finish.
- Pointer advance: next = ptr + BURST_LEN; if next >= ADDR_BASE+ADDR_SPAN, next = ADDR_BASE. Arithmetic is in APP_ADDR_WIDTH+1 bits to avoid overflow.
- Clear pulses:
  - wr_addr_clr / rd_addr_clr in IDLE, or at the same cycle as a finish of the other side: pointer <= ADDR_BASE next cycle.
  - During own side's REQ/WAIT: latched pending; applied at finish instead of the advance.
  - Clear coincident with own finish: clear wins.
- enable falling mid-burst does not abort; the burst completes and the block then stays in IDLE.
- A request is never reasserted in the same cycle as a finish; minimum one IDLE cycle between bursts.
- No timeout: a core that never finishes leaves the block in WAIT until reset.
- Reset mid-burst: immediate return to reset values; in-flight core burst is the core's concern (both are reset together).

Test Plan:
- wr_fifo_level=300, rd_fifo_free=0, BURST_LEN=256, base 0 -> wr_burst_req high 1 cycle after IDLE sample, wr_burst_addr=0; 256 wr_fifo_rd_en pulses; after finish wr_ptr=256.
- Both eligible continuously -> grants alternate W,R,W,R starting with W after reset; addresses 0,0,256,256.
- ADDR_SPAN=1024, four write bursts -> addresses 0,256,512,768, fifth burst at 0.
- wr_addr_clr pulsed during WR_WAIT of burst at 512 -> next write burst addr 0, not 768.
- enable dropped during RD_WAIT -> rd burst completes (256 rd_fifo_wr_en), busy falls, no new req while FIFOs stay eligible.
- rst_n low during WR_WAIT -> wr_burst_req=0, busy=0, pointers = ADDR_BASE immediately (async).
